// File: rtl/sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sequencer_if
// Description : Bus bundle between the sequencer and its ROM, register file
//               and ALU.
//               master : sequencer side (drives fetch, register-file and ALU
//                        controls plus the status flags)
//               slave  : environment side (returns the instruction word,
//                        register read data and the ALU result)
//               Signals:
//                 rom_enable/rom_addr, rom_data           instruction ROM
//                 gpr_r_addr_a/b, gpr_r_data_a/b          register reads
//                 gpr_w_enable/gpr_w_addr/gpr_w_data      register write
//                 alu_operation/alu_A/alu_B, alu_C        ALU
//                 halted, illegal                         status
// Revision    : 1.0 - initial release
// ============================================================================
interface sequencer_if;
    logic        rom_enable;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic [2:0]  gpr_r_addr_a;
    logic [2:0]  gpr_r_addr_b;
    logic [7:0]  gpr_r_data_a;
    logic [7:0]  gpr_r_data_b;
    logic        gpr_w_enable;
    logic [2:0]  gpr_w_addr;
    logic [7:0]  gpr_w_data;
    logic [2:0]  alu_operation;
    logic [7:0]  alu_A;
    logic [7:0]  alu_B;
    logic [7:0]  alu_C;
    logic        halted;
    logic        illegal;

    modport master (
        output rom_enable, rom_addr,
        input  rom_data,
        output gpr_r_addr_a, gpr_r_addr_b,
        input  gpr_r_data_a, gpr_r_data_b,
        output gpr_w_enable, gpr_w_addr, gpr_w_data,
        output alu_operation, alu_A, alu_B,
        input  alu_C,
        output halted, illegal
    );

    modport slave (
        input  rom_enable, rom_addr,
        output rom_data,
        input  gpr_r_addr_a, gpr_r_addr_b,
        output gpr_r_data_a, gpr_r_data_b,
        input  gpr_w_enable, gpr_w_addr, gpr_w_data,
        input  alu_operation, alu_A, alu_B,
        output alu_C,
        input  halted, illegal
    );
endinterface
`default_nettype wire

// File: rtl/sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sequencer
// Description : Four-phase (FETCH/DECODE/EXECUTE/WRITEBACK) instruction
//               sequencer driving an external ROM, register file and ALU.
//               Ports:
//                 clk  - single clock, rising edge
//                 rst  - synchronous reset, active low
//                 run  - 1 allows a fetch, 0 stalls in FETCH
//                 bus  - sequencer_if.master (ROM, register file, ALU,
//                        halted/illegal status)
// Revision    : 1.0 - initial release
// ============================================================================
module sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     run,
    sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    localparam logic [2:0] c_OP_ALU  = 3'b000;
    localparam logic [2:0] c_OP_LDI  = 3'b001;
    localparam logic [2:0] c_OP_JMP  = 3'b010;
    localparam logic [2:0] c_OP_BEQZ = 3'b011;
    localparam logic [2:0] c_OP_NOP  = 3'b100;
    localparam logic [2:0] c_OP_HALT = 3'b111;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [23:0] ir_q, ir_d;
    logic [7:0]  result_q, result_d;
    logic        wen_q, wen_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;

    // Instruction fields
    logic [2:0] w_op;
    logic [2:0] w_alu_op;
    logic [2:0] w_rd;
    logic [2:0] w_ra;
    logic [2:0] w_rb;
    logic [7:0] w_imm;
    logic       w_unused_ir_bit8;

    assign w_op             = ir_q[23:21];
    assign w_alu_op         = ir_q[20:18];
    assign w_rd             = ir_q[17:15];
    assign w_ra             = ir_q[14:12];
    assign w_rb             = ir_q[11:9];
    assign w_imm            = ir_q[7:0];
    assign w_unused_ir_bit8 = ir_q[8];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        result_d  = result_q;
        wen_d     = 1'b0;
        halted_d  = halted_q;
        illegal_d = illegal_q;

        case (state_q)
            S_FETCH: begin
                if (run) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // ROM data answers the strobe issued in FETCH
                ir_d    = bus.rom_data;
                pc_d    = pc_q + 8'd1;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
                // wen_d here becomes the one-cycle write strobe in WRITEBACK
                case (w_op)
                    c_OP_ALU: begin
                        result_d = bus.alu_C;
                        wen_d    = 1'b1;
                    end
                    c_OP_LDI: begin
                        result_d = w_imm;
                        wen_d    = 1'b1;
                    end
                    c_OP_JMP: begin
                        pc_d = w_imm;
                    end
                    c_OP_BEQZ: begin
                        if (bus.gpr_r_data_a == 8'h00) begin
                            pc_d = w_imm;
                        end
                    end
                    c_OP_NOP: begin
                    end
                    c_OP_HALT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    default: begin
                        // Unassigned opcodes flag and otherwise act as NOP
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_WRITEBACK: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 24'h000000;
            result_q  <= 8'h00;
            wen_q     <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            result_q  <= result_d;
            wen_q     <= wen_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // The ROM strobe must react to run within the FETCH cycle itself, and is
    // gated by rst so no fetch is issued while reset is held.
    assign bus.rom_enable    = (state_q == S_FETCH) && run && rst;
    assign bus.rom_addr      = pc_q;
    assign bus.gpr_r_addr_a  = w_ra;
    assign bus.gpr_r_addr_b  = w_rb;
    assign bus.alu_operation = w_alu_op;
    assign bus.alu_A         = bus.gpr_r_data_a;
    assign bus.alu_B         = bus.gpr_r_data_b;
    assign bus.gpr_w_enable  = wen_q;
    assign bus.gpr_w_addr    = w_rd;
    assign bus.gpr_w_data    = result_q;
    assign bus.halted        = halted_q;
    assign bus.illegal       = illegal_q;

endmodule
`default_nettype wire
